// File: rtl/axi4l_arbiter2_if.sv
// AXI4-Lite shared types and bus interface.
//
// axi4l_pkg : address, data, strobe and response types used by every
//             AXI4-Lite port in the design.
// axi4l_if  : one AXI4-Lite link (AW, W, B, AR, R channels).
//   modport master : drives AW/W/AR payload and valids, B/R readies.
//   modport slave  : drives AW/W/AR readies, B/R payload and valids.

package axi4l_pkg;
    typedef logic [31:0] addr_t;
    typedef logic [31:0] data_t;
    typedef logic [3:0]  strb_t;
    typedef logic [1:0]  resp_t;
endpackage

interface axi4l_if;
    axi4l_pkg::addr_t awaddr;
    logic             awvalid;
    logic             awready;
    axi4l_pkg::data_t wdata;
    axi4l_pkg::strb_t wstrb;
    logic             wvalid;
    logic             wready;
    axi4l_pkg::resp_t bresp;
    logic             bvalid;
    logic             bready;
    axi4l_pkg::addr_t araddr;
    logic             arvalid;
    logic             arready;
    axi4l_pkg::data_t rdata;
    axi4l_pkg::resp_t rresp;
    logic             rvalid;
    logic             rready;

    modport master (
        output awaddr, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready
    );

    modport slave (
        input  awaddr, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axi4l_arbiter2.sv
// Two-master / one-slave AXI4-Lite arbiter.
//
// The write path (AW+W+B) and the read path (AR+R) are arbitrated by two
// independent FSMs, each holding at most one transaction in flight. The
// grant is registered in the IDLE state; all forwarding afterwards is a
// combinational mux steered by that registered grant.
//
// Ports:
//   aclk   : clock, rising edge.
//   areset : synchronous active-high reset.
//   m0     : master port 0 (wins the first contended arbitration).
//   m1     : master port 1.
//   s      : shared downstream slave.
//
// Configuration macro:
//   AXI4L_ARB_FIXED_PRIO_EN : when defined the round-robin pointers never
//   advance, so m0 always wins simultaneous requests (m1 may starve).
//   Default (undefined): round-robin, pointer moves to the other master
//   after every completed transaction.

module axi4l_arbiter2 (
    input  logic    aclk,
    input  logic    areset,
    axi4l_if.slave  m0,
    axi4l_if.slave  m1,
    axi4l_if.master s
);

    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_t;

    // ------------------------------------------------------------------
    // Write channel state
    // ------------------------------------------------------------------
    wstate_t w_state, w_state_next;
    logic    wgnt, wgnt_next;       // 0 = m0, 1 = m1
    logic    wptr, wptr_next;       // preferred master on contention
    logic    aw_done, aw_done_next;
    logic    w_done, w_done_next;

    // ------------------------------------------------------------------
    // Read channel state
    // ------------------------------------------------------------------
    rstate_t r_state, r_state_next;
    logic    rgnt, rgnt_next;
    logic    rptr, rptr_next;

    // Requests seen in IDLE
    logic w_req0, w_req1, r_req0, r_req1;

    // Granted-master views of master-driven handshake signals
    logic sel_awvalid, sel_wvalid, sel_bready, sel_arvalid, sel_rready;

    // Channel phase enables derived from registered state only
    logic fwd_aw, fwd_w, fwd_b, fwd_ar, fwd_r;

    // Slave-side handshakes
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

    assign w_req0 = m0.awvalid || m0.wvalid;
    assign w_req1 = m1.awvalid || m1.wvalid;
    assign r_req0 = m0.arvalid;
    assign r_req1 = m1.arvalid;

    assign sel_awvalid = wgnt ? m1.awvalid : m0.awvalid;
    assign sel_wvalid  = wgnt ? m1.wvalid  : m0.wvalid;
    assign sel_bready  = wgnt ? m1.bready  : m0.bready;
    assign sel_arvalid = rgnt ? m1.arvalid : m0.arvalid;
    assign sel_rready  = rgnt ? m1.rready  : m0.rready;

    // A completed AW or W phase stays masked until the transaction ends so
    // the slave never sees a second valid for the same beat.
    assign fwd_aw = (w_state == W_ADDR) && !aw_done;
    assign fwd_w  = (w_state == W_ADDR) && !w_done;
    assign fwd_b  = (w_state == W_RESP);
    assign fwd_ar = (r_state == R_ADDR);
    assign fwd_r  = (r_state == R_DATA);

    assign aw_hs = s.awvalid && s.awready;
    assign w_hs  = s.wvalid  && s.wready;
    assign b_hs  = s.bvalid  && s.bready;
    assign ar_hs = s.arvalid && s.arready;
    assign r_hs  = s.rvalid  && s.rready;

    // ------------------------------------------------------------------
    // Slave-side outputs
    // ------------------------------------------------------------------
    assign s.awvalid = fwd_aw && sel_awvalid;
    assign s.awaddr  = wgnt ? m1.awaddr : m0.awaddr;
    assign s.wvalid  = fwd_w && sel_wvalid;
    assign s.wdata   = wgnt ? m1.wdata : m0.wdata;
    assign s.wstrb   = wgnt ? m1.wstrb : m0.wstrb;
    assign s.bready  = fwd_b && sel_bready;
    assign s.arvalid = fwd_ar && sel_arvalid;
    assign s.araddr  = rgnt ? m1.araddr : m0.araddr;
    assign s.rready  = fwd_r && sel_rready;

    // ------------------------------------------------------------------
    // Master-side outputs: only the granted master sees ready/valid.
    // Response payloads go to both masters unconditionally.
    // ------------------------------------------------------------------
    assign m0.awready = fwd_aw && !wgnt && s.awready;
    assign m1.awready = fwd_aw &&  wgnt && s.awready;
    assign m0.wready  = fwd_w  && !wgnt && s.wready;
    assign m1.wready  = fwd_w  &&  wgnt && s.wready;
    assign m0.bvalid  = fwd_b  && !wgnt && s.bvalid;
    assign m1.bvalid  = fwd_b  &&  wgnt && s.bvalid;
    assign m0.bresp   = s.bresp;
    assign m1.bresp   = s.bresp;

    assign m0.arready = fwd_ar && !rgnt && s.arready;
    assign m1.arready = fwd_ar &&  rgnt && s.arready;
    assign m0.rvalid  = fwd_r  && !rgnt && s.rvalid;
    assign m1.rvalid  = fwd_r  &&  rgnt && s.rvalid;
    assign m0.rdata   = s.rdata;
    assign m1.rdata   = s.rdata;
    assign m0.rresp   = s.rresp;
    assign m1.rresp   = s.rresp;

    // ------------------------------------------------------------------
    // Write FSM
    // ------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (areset) begin
            w_state <= W_IDLE;
            wgnt    <= 1'b0;
            wptr    <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            w_state <= w_state_next;
            wgnt    <= wgnt_next;
            wptr    <= wptr_next;
            aw_done <= aw_done_next;
            w_done  <= w_done_next;
        end
    end

    always_comb begin
        w_state_next = w_state;
        wgnt_next    = wgnt;
        wptr_next    = wptr;
        aw_done_next = aw_done;
        w_done_next  = w_done;
        unique case (w_state)
            W_IDLE: begin
                if (w_req0 || w_req1) begin
                    wgnt_next    = (w_req0 && w_req1) ? wptr : w_req1;
                    w_state_next = W_ADDR;
                end
            end
            W_ADDR: begin
                if (aw_hs) aw_done_next = 1'b1;
                if (w_hs)  w_done_next  = 1'b1;
                // Advance in the same cycle the later of AW/W completes.
                if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                    w_state_next = W_RESP;
                end
            end
            W_RESP: begin
                if (b_hs) begin
                    w_state_next = W_IDLE;
                    aw_done_next = 1'b0;
                    w_done_next  = 1'b0;
`ifdef AXI4L_ARB_FIXED_PRIO_EN
                    wptr_next    = wptr;
`else
                    wptr_next    = ~wgnt;
`endif
                end
            end
            default: w_state_next = W_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Read FSM
    // ------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state <= R_IDLE;
            rgnt    <= 1'b0;
            rptr    <= 1'b0;
        end else begin
            r_state <= r_state_next;
            rgnt    <= rgnt_next;
            rptr    <= rptr_next;
        end
    end

    always_comb begin
        r_state_next = r_state;
        rgnt_next    = rgnt;
        rptr_next    = rptr;
        unique case (r_state)
            R_IDLE: begin
                if (r_req0 || r_req1) begin
                    rgnt_next    = (r_req0 && r_req1) ? rptr : r_req1;
                    r_state_next = R_ADDR;
                end
            end
            R_ADDR: begin
                if (ar_hs) r_state_next = R_DATA;
            end
            R_DATA: begin
                if (r_hs) begin
                    r_state_next = R_IDLE;
`ifdef AXI4L_ARB_FIXED_PRIO_EN
                    rptr_next    = rptr;
`else
                    rptr_next    = ~rgnt;
`endif
                end
            end
            default: r_state_next = R_IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi4l_arbiter2.sv
// Testbench for axi4l_arbiter2: two behavioural masters, a one-register
// LED slave (addr 0x000 OKAY, any other address SLVERR), a table of
// single transactions plus hand-written contention, skew, concurrency,
// backpressure and reset sequences.

module tb_axi4l_arbiter2;
    import axi4l_pkg::*;

    localparam resp_t OKAY   = 2'b00;
    localparam resp_t SLVERR = 2'b10;
`ifdef AXI4L_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic aclk = 1'b0;
    logic areset = 1'b1;
    always #5 aclk = ~aclk;

    int unsigned cycle = 0;
    always @(posedge aclk) cycle <= cycle + 1;

    axi4l_if m0_if ();
    axi4l_if m1_if ();
    axi4l_if s_if ();

    axi4l_arbiter2 dut (
        .aclk  (aclk),
        .areset(areset),
        .m0    (m0_if),
        .m1    (m1_if),
        .s     (s_if)
    );

    // ---------------- master drive / observe arrays ----------------
    logic  mav[2], mwv[2], mbr[2], marv[2], mrr[2];
    addr_t maw[2], mar[2];
    data_t mwd[2];
    strb_t mws[2];

    assign m0_if.awvalid = mav[0];  assign m1_if.awvalid = mav[1];
    assign m0_if.awaddr  = maw[0];  assign m1_if.awaddr  = maw[1];
    assign m0_if.wvalid  = mwv[0];  assign m1_if.wvalid  = mwv[1];
    assign m0_if.wdata   = mwd[0];  assign m1_if.wdata   = mwd[1];
    assign m0_if.wstrb   = mws[0];  assign m1_if.wstrb   = mws[1];
    assign m0_if.bready  = mbr[0];  assign m1_if.bready  = mbr[1];
    assign m0_if.arvalid = marv[0]; assign m1_if.arvalid = marv[1];
    assign m0_if.araddr  = mar[0];  assign m1_if.araddr  = mar[1];
    assign m0_if.rready  = mrr[0];  assign m1_if.rready  = mrr[1];

    logic  awr[2], wr[2], bv[2], arr[2], rv[2];
    resp_t br[2], rr[2];
    data_t rd[2];

    assign awr[0] = m0_if.awready; assign awr[1] = m1_if.awready;
    assign wr[0]  = m0_if.wready;  assign wr[1]  = m1_if.wready;
    assign bv[0]  = m0_if.bvalid;  assign bv[1]  = m1_if.bvalid;
    assign br[0]  = m0_if.bresp;   assign br[1]  = m1_if.bresp;
    assign arr[0] = m0_if.arready; assign arr[1] = m1_if.arready;
    assign rv[0]  = m0_if.rvalid;  assign rv[1]  = m1_if.rvalid;
    assign rr[0]  = m0_if.rresp;   assign rr[1]  = m1_if.rresp;
    assign rd[0]  = m0_if.rdata;   assign rd[1]  = m1_if.rdata;

    // ---------------- LED slave model ----------------
    logic        s_aw_got, s_w_got;
    addr_t       s_awa;
    data_t       s_wd;
    strb_t       s_ws;
    data_t       led;
    int unsigned s_wr_count = 0;

    assign s_if.awready = !s_aw_got;
    assign s_if.wready  = !s_w_got;
    assign s_if.arready = !s_if.rvalid;

    always @(posedge aclk) begin
        if (areset) begin
            s_aw_got    <= 1'b0;
            s_w_got     <= 1'b0;
            s_awa       <= '0;
            s_wd        <= '0;
            s_ws        <= '0;
            led         <= '0;
            s_if.bvalid <= 1'b0;
            s_if.bresp  <= OKAY;
            s_if.rvalid <= 1'b0;
            s_if.rresp  <= OKAY;
            s_if.rdata  <= '0;
        end else begin
            if (s_if.awvalid && s_if.awready) begin
                s_aw_got <= 1'b1;
                s_awa    <= s_if.awaddr;
            end
            if (s_if.wvalid && s_if.wready) begin
                s_w_got <= 1'b1;
                s_wd    <= s_if.wdata;
                s_ws    <= s_if.wstrb;
            end
            if (s_aw_got && s_w_got && !s_if.bvalid) begin
                s_if.bvalid <= 1'b1;
                s_wr_count  <= s_wr_count + 1;
                if (s_awa == 32'h0) begin
                    for (int i = 0; i < 4; i++)
                        if (s_ws[i]) led[8*i +: 8] <= s_wd[8*i +: 8];
                    s_if.bresp <= OKAY;
                end else begin
                    s_if.bresp <= SLVERR;
                end
            end
            if (s_if.bvalid && s_if.bready) begin
                s_if.bvalid <= 1'b0;
                s_aw_got    <= 1'b0;
                s_w_got     <= 1'b0;
            end
            if (s_if.arvalid && s_if.arready) begin
                s_if.rvalid <= 1'b1;
                s_if.rdata  <= (s_if.araddr == 32'h0) ? led : 32'h0;
                s_if.rresp  <= (s_if.araddr == 32'h0) ? OKAY : SLVERR;
            end
            if (s_if.rvalid && s_if.rready) s_if.rvalid <= 1'b0;
        end
    end

    // ---------------- stray response monitor ----------------
    bit          exp_b[2], exp_r[2];
    int unsigned stray = 0;
    always @(negedge aclk) begin
        for (int i = 0; i < 2; i++) begin
            if (bv[i] === 1'b1 && !exp_b[i]) stray++;
            if (rv[i] === 1'b1 && !exp_r[i]) stray++;
        end
    end

    // ---------------- checking ----------------
    int unsigned n_cmp = 0;
    int unsigned n_fail = 0;
    bit          wptr_m = 1'b0;   // expected write-pointer value

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_idle(input string name);
        logic [14:0] v;
        v = {awr[0], wr[0], bv[0], arr[0], rv[0],
             awr[1], wr[1], bv[1], arr[1], rv[1],
             s_if.awvalid, s_if.wvalid, s_if.bready, s_if.arvalid, s_if.rready};
        check(name, {17'd0, v}, 32'd0);
    endtask

    task automatic do_write(input int m, input addr_t a, input data_t d,
                            input int aw_delay, input int b_delay,
                            output resp_t resp, output int unsigned done_at);
        bit aw_done, w_done, ahs, whs, early, leak, stall_bad;
        int cyc;
        aw_done = 0; w_done = 0; early = 0; leak = 0; stall_bad = 0;
        cyc = 0; resp = 2'b11;
        exp_b[m] = 1'b1;
        maw[m] = a; mwd[m] = d; mws[m] = 4'hF;
        mwv[m] = 1'b1; mbr[m] = (b_delay == 0);
        while (!(aw_done && w_done) && cyc <= 200) begin
            if (cyc == aw_delay) mav[m] = 1'b1;
            ahs = mav[m] && awr[m];
            whs = mwv[m] && wr[m];
            if (bv[m]) early = 1;
            if ((w_done && s_if.wvalid) || (aw_done && s_if.awvalid)) leak = 1;
            @(posedge aclk); #1; cyc++;
            if (ahs) begin mav[m] = 1'b0; aw_done = 1; end
            if (whs) begin mwv[m] = 1'b0; w_done = 1; end
        end
        while (!bv[m] && cyc <= 200) begin
            @(posedge aclk); #1; cyc++;
        end
        if (cyc > 200) begin
            n_cmp++; n_fail++;
            $display("FAIL wr_timeout_m%0d: got no B after %0d cycles, expected B", m, cyc);
            mav[m] = 1'b0; mwv[m] = 1'b0;
        end else begin
            resp = br[m];
            for (int i = 0; i < b_delay; i++) begin
                @(posedge aclk); #1;
                if (!bv[m] || s_if.awvalid || s_if.wvalid || awr[1-m] || wr[1-m]) stall_bad = 1;
            end
            mbr[m] = 1'b1;
            @(posedge aclk); #1;
        end
        mbr[m] = 1'b0;
        exp_b[m] = 1'b0;
        done_at = cycle;
        wptr_m = FIXED ? 1'b0 : (m == 0);
        check($sformatf("wr_early_b_m%0d", m), {31'd0, early}, 32'd0);
        check($sformatf("wr_valid_leak_m%0d", m), {31'd0, leak}, 32'd0);
        if (b_delay > 0) check($sformatf("wr_bstall_m%0d", m), {31'd0, stall_bad}, 32'd0);
    endtask

    task automatic do_read(input int m, input addr_t a, output resp_t resp, output data_t d);
        bit hs;
        int cyc;
        hs = 0; cyc = 0; resp = 2'b11; d = '1;
        exp_r[m] = 1'b1;
        mar[m] = a; marv[m] = 1'b1; mrr[m] = 1'b1;
        while (!hs && cyc <= 200) begin
            hs = marv[m] && arr[m];
            @(posedge aclk); #1; cyc++;
        end
        marv[m] = 1'b0;
        while (!rv[m] && cyc <= 200) begin
            @(posedge aclk); #1; cyc++;
        end
        if (cyc > 200) begin
            n_cmp++; n_fail++;
            $display("FAIL rd_timeout_m%0d: got no R after %0d cycles, expected R", m, cyc);
        end else begin
            resp = rr[m];
            d = rd[m];
            @(posedge aclk); #1;
        end
        mrr[m] = 1'b0;
        exp_r[m] = 1'b0;
    endtask

    typedef struct {
        int    m;
        bit    wr;
        addr_t a;
        data_t d;
        resp_t er;
        data_t ed;
    } vec_t;

    initial begin
        vec_t        vecs[8];
        resp_t       r0, r1;
        data_t       d1, old;
        int unsigned t0, t1, wc;
        bit          exp_first;
        int          n;

        // LED starts at 0xA from the single-write sequence below.
        vecs[0] = '{0, 1'b0, 32'h000, 32'h0,  OKAY,   32'hA};
        vecs[1] = '{1, 1'b0, 32'h000, 32'h0,  OKAY,   32'hA};
        vecs[2] = '{1, 1'b0, 32'h004, 32'h0,  SLVERR, 32'h0};
        vecs[3] = '{1, 1'b1, 32'h000, 32'h33, OKAY,   32'h0};
        vecs[4] = '{0, 1'b0, 32'h000, 32'h0,  OKAY,   32'h33};
        vecs[5] = '{0, 1'b1, 32'h008, 32'h1,  SLVERR, 32'h0};
        vecs[6] = '{1, 1'b1, 32'h000, 32'h44, OKAY,   32'h0};
        vecs[7] = '{1, 1'b0, 32'h000, 32'h0,  OKAY,   32'h44};

        for (int i = 0; i < 2; i++) begin
            mav[i] = 0; mwv[i] = 0; mbr[i] = 0; marv[i] = 0; mrr[i] = 0;
            maw[i] = '0; mar[i] = '0; mwd[i] = '0; mws[i] = '0;
            exp_b[i] = 0; exp_r[i] = 0;
        end

        areset = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        check_idle("reset_idle");
        areset = 1'b0;
        @(posedge aclk); #1;

        // Single write with grant-latency probe.
        fork
            do_write(0, 32'h000, 32'h0000_000A, 0, 0, r0, t0);
            begin
                #2;
                check("lat_awvalid_same_cycle", {31'd0, s_if.awvalid}, 32'd0);
                @(posedge aclk); #1;
                check("lat_awvalid_next_cycle", {31'd0, s_if.awvalid}, 32'd1);
                check("lat_awaddr", s_if.awaddr, 32'h0);
            end
        join
        check("single_bresp", {30'd0, r0}, {30'd0, OKAY});
        check("single_led", led, 32'hA);

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].wr) begin
                do_write(vecs[i].m, vecs[i].a, vecs[i].d, 0, 0, r0, t0);
                check($sformatf("vec%0d_bresp", i), {30'd0, r0}, {30'd0, vecs[i].er});
            end else begin
                do_read(vecs[i].m, vecs[i].a, r0, d1);
                check($sformatf("vec%0d_rresp", i), {30'd0, r0}, {30'd0, vecs[i].er});
                check($sformatf("vec%0d_rdata", i), d1, vecs[i].ed);
            end
        end

        // Contention 1: pointer decides.
        exp_first = wptr_m;
        fork
            do_write(0, 32'h000, 32'h1, 0, 0, r0, t0);
            do_write(1, 32'h000, 32'h2, 0, 0, r1, t1);
        join
        check("cont1_m1_first", {31'd0, (t1 < t0)}, {31'd0, exp_first});
        check("cont1_led", led, exp_first ? 32'h1 : 32'h2);
        check("cont1_gap_ge3", {31'd0, ((t0 > t1 ? t0 - t1 : t1 - t0) >= 3)}, 32'd1);

        // One m0 write flips the round-robin pointer towards m1.
        do_write(0, 32'h000, 32'h7, 0, 0, r0, t0);
        exp_first = wptr_m;
        fork
            do_write(0, 32'h000, 32'h1, 0, 0, r0, t0);
            do_write(1, 32'h000, 32'h2, 0, 0, r1, t1);
        join
        check("cont2_m1_first", {31'd0, (t1 < t0)}, {31'd0, exp_first});
        check("cont2_led", led, exp_first ? 32'h1 : 32'h2);

        // W leads AW by 3 cycles.
        wc = s_wr_count;
        do_write(1, 32'h000, 32'h55, 3, 0, r1, t1);
        check("skew_one_write", s_wr_count - wc, 32'd1);
        check("skew_bresp", {30'd0, r1}, {30'd0, OKAY});
        check("skew_led", led, 32'h55);

        // Concurrent write (m0) and read (m1).
        old = led;
        fork
            do_write(0, 32'h000, 32'h5, 0, 0, r0, t0);
            do_read(1, 32'h000, r1, d1);
        join
        check("conc_bresp", {30'd0, r0}, {30'd0, OKAY});
        check("conc_rresp", {30'd0, r1}, {30'd0, OKAY});
        check("conc_rdata_old_or_new", {31'd0, (d1 == old || d1 == 32'h5)}, 32'd1);
        check("conc_led", led, 32'h5);

        do_read(1, 32'h004, r1, d1);
        check("err_rresp_m1", {30'd0, r1}, {30'd0, SLVERR});

        // B backpressure on m0 holds off m1.
        fork
            do_write(0, 32'h000, 32'h66, 0, 5, r0, t0);
            begin
                repeat (2) @(posedge aclk);
                #1;
                do_write(1, 32'h000, 32'h77, 0, 0, r1, t1);
            end
        join
        check("bp_m1_after_m0", {31'd0, (t1 > t0)}, 32'd1);
        check("bp_led", led, 32'h77);

        // Reset during W_RESP.
        do_write(0, 32'h000, 32'h88, 0, 0, r0, t0);
        exp_b[0] = 1'b1;
        maw[0] = 32'h0; mwd[0] = 32'h99; mws[0] = 4'hF;
        mav[0] = 1'b1; mwv[0] = 1'b1; mbr[0] = 1'b0;
        n = 0;
        while (!bv[0] && n < 50) begin
            @(posedge aclk); #1; n++;
        end
        check("rst_bvalid_pending", {31'd0, bv[0]}, 32'd1);
        areset = 1'b1;
        mav[0] = 1'b0; mwv[0] = 1'b0;
        @(posedge aclk); #1;
        check_idle("rst_mid_idle");
        areset = 1'b0;
        exp_b[0] = 1'b0;
        wptr_m = 1'b0;
        @(posedge aclk); #1;
        exp_first = wptr_m;
        fork
            do_write(0, 32'h000, 32'h1, 0, 0, r0, t0);
            do_write(1, 32'h000, 32'h2, 0, 0, r1, t1);
        join
        check("rst_wptr_m1_first", {31'd0, (t1 < t0)}, {31'd0, exp_first});

        check("stray_valids", stray, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
